latch_strobe_gen: RTL and testbench

LATCH_STROBE_GEN -- requirements
Module: latch_strobe_gen

---
 rtl/latch_strobe_gen.sv | 170 +++++++++++++++++
 tb/tb_latch_strobe_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_strobe_gen.sv
// Drives a latched parallel bus with a timed setup/strobe/hold sequence per request.
// Define LATCH_QUEUE_EN to add a one-entry request queue for back-to-back transfers.
module latch_strobe_gen #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned SETUP_CYCLES  = 2,
   parameter int unsigned STROBE_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES   = 2
) (
   input  logic                  sys_clock,
   input  logic                  reset_n,
   input  logic                  req,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] latch_data,
   output logic                  bus_drive,
   output logic                  latch_strobe,
   output logic                  done
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

   // Reject phase lengths the 8-bit phase counter cannot represent.
   if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255) begin : g_bad_setup
      $error("latch_strobe_gen: SETUP_CYCLES must be 1..255");
   end
   if (STROBE_CYCLES < 1 || STROBE_CYCLES > 255) begin : g_bad_strobe
      $error("latch_strobe_gen: STROBE_CYCLES must be 1..255");
   end
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
      $error("latch_strobe_gen: HOLD_CYCLES must be 1..255");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t                state, state_d;
   logic [CNT_W-1:0]      cnt, cnt_d;
   logic                  ready_d, bus_drive_d, latch_strobe_d, done_d;
   logic [DATA_WIDTH-1:0] latch_data_d;
   logic                  accept, phase_end;

`ifdef LATCH_QUEUE_EN
   logic                  q_full, q_full_d;
   logic [DATA_WIDTH-1:0] q_data, q_data_d;
`endif

   assign accept    = req & ready;
   assign phase_end = (cnt == CNT_W'(0));

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_d        = state;
      cnt_d          = cnt;
      bus_drive_d    = bus_drive;
      latch_strobe_d = latch_strobe;
      done_d         = 1'b0;
      latch_data_d   = latch_data;
`ifdef LATCH_QUEUE_EN
      q_full_d       = q_full;
      q_data_d       = q_data;
`endif
      case (state)
         IDLE: begin
            if (accept) begin
               state_d      = SETUP;
               cnt_d        = SETUP_LOAD;
               bus_drive_d  = 1'b1;
               latch_data_d = req_data;
            end
         end
         SETUP: begin
            if (phase_end) begin
               state_d        = STROBE;
               cnt_d          = STROBE_LOAD;
               latch_strobe_d = 1'b1;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         STROBE: begin
            if (phase_end) begin
               state_d        = HOLD;
               cnt_d          = HOLD_LOAD;
               latch_strobe_d = 1'b0;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         HOLD: begin
            if (phase_end) begin
               done_d      = 1'b1;
               state_d     = IDLE;
               bus_drive_d = 1'b0;
`ifdef LATCH_QUEUE_EN
               // Chain the next transfer at this edge without releasing the bus.
               if (q_full) begin
                  state_d      = SETUP;
                  cnt_d        = SETUP_LOAD;
                  bus_drive_d  = 1'b1;
                  latch_data_d = q_data;
                  q_full_d     = accept;
                  if (accept) begin
                     q_data_d = req_data;
                  end
               end else if (accept) begin
                  state_d      = SETUP;
                  cnt_d        = SETUP_LOAD;
                  bus_drive_d  = 1'b1;
                  latch_data_d = req_data;
               end
`endif
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
`ifdef LATCH_QUEUE_EN
      if (accept && state != IDLE && !(state == HOLD && phase_end)) begin
         q_full_d = 1'b1;
         q_data_d = req_data;
      end
      ready_d = ~q_full_d;
`else
      ready_d = (state_d == IDLE);
`endif
   end

   always_ff @(posedge sys_clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         ready        <= 1'b0;
         bus_drive    <= 1'b0;
         latch_strobe <= 1'b0;
         done         <= 1'b0;
         latch_data   <= '0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         ready        <= ready_d;
         bus_drive    <= bus_drive_d;
         latch_strobe <= latch_strobe_d;
         done         <= done_d;
         latch_data   <= latch_data_d;
      end
   end

`ifdef LATCH_QUEUE_EN
   always_ff @(posedge sys_clock or negedge reset_n) begin
      if (!reset_n) begin
         q_full <= 1'b0;
         q_data <= '0;
      end else begin
         q_full <= q_full_d;
         q_data <= q_data_d;
      end
   end
`endif

endmodule

// File: tb/tb_latch_strobe_gen.sv
// Directed bench for latch_strobe_gen: default timing instance plus a 1/1/1 timing instance.
module tb_latch_strobe_gen;

   logic       sys_clock;
   logic       reset_n;
   logic       req, req_m;
   logic [7:0] req_data, req_data_m;
   logic       ready, ready_m;
   logic [7:0] latch_data, latch_data_m;
   logic       bus_drive, bus_drive_m;
   logic       latch_strobe, latch_strobe_m;
   logic       done, done_m;

   int n_checks;
   int n_fail;

   latch_strobe_gen dut (
      .sys_clock    (sys_clock),
      .reset_n      (reset_n),
      .req          (req),
      .req_data     (req_data),
      .ready        (ready),
      .latch_data   (latch_data),
      .bus_drive    (bus_drive),
      .latch_strobe (latch_strobe),
      .done         (done)
   );

   latch_strobe_gen #(
      .SETUP_CYCLES  (1),
      .STROBE_CYCLES (1),
      .HOLD_CYCLES   (1)
   ) dut_min (
      .sys_clock    (sys_clock),
      .reset_n      (reset_n),
      .req          (req_m),
      .req_data     (req_data_m),
      .ready        (ready_m),
      .latch_data   (latch_data_m),
      .bus_drive    (bus_drive_m),
      .latch_strobe (latch_strobe_m),
      .done         (done_m)
   );

   initial sys_clock = 1'b0;
   always #5 sys_clock = ~sys_clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clock);
      #1;
   endtask

   task automatic wait_ready();
      int budget;
      budget = 40;
      while (!ready && budget > 0) begin
         tick();
         budget--;
      end
      check("wait_ready", 32'(ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset_n    = 1'b0;
      req        = 1'b0;
      req_data   = 8'h00;
      req_m      = 1'b0;
      req_data_m = 8'h00;

      // Reset state
      #1;
      check("rst ready",  32'(ready),        32'd0);
      check("rst bus",    32'(bus_drive),    32'd0);
      check("rst strobe", 32'(latch_strobe), 32'd0);
      check("rst done",   32'(done),         32'd0);
      check("rst data",   32'(latch_data),   32'd0);
      repeat (3) tick();
      check("rst hold ready", 32'(ready), 32'd0);
      reset_n = 1'b1;
      check("release ready pre-edge", 32'(ready), 32'd0);
      tick();
      check("release ready", 32'(ready),   32'd1);
      check("release ready_m", 32'(ready_m), 32'd1);

      // Single transfer 0xA5
      req = 1'b1;
      req_data = 8'hA5;
      tick();
      req = 1'b0;
      req_data = 8'h00;
      check("a5 e0 bus",    32'(bus_drive),    32'd1);
      check("a5 e0 strobe", 32'(latch_strobe), 32'd0);
      check("a5 e0 data",   32'(latch_data),   32'hA5);
`ifndef LATCH_QUEUE_EN
      check("a5 e0 ready",  32'(ready),        32'd0);
`endif
      for (int k = 1; k <= 9; k++) begin
         tick();
         check($sformatf("a5 strobe@%0d", k), 32'(latch_strobe), 32'(k >= 2 && k < 6));
         check($sformatf("a5 bus@%0d", k),    32'(bus_drive),    32'(k < 8));
         check($sformatf("a5 done@%0d", k),   32'(done),         32'(k == 8));
         check($sformatf("a5 data@%0d", k),   32'(latch_data),   32'hA5);
`ifndef LATCH_QUEUE_EN
         check($sformatf("a5 ready@%0d", k),  32'(ready),        32'(k >= 8));
`endif
      end

      // req_data churn during a transfer of 0x3C
      wait_ready();
      req = 1'b1;
      req_data = 8'h3C;
      tick();
      req = 1'b0;
      check("3c data@0", 32'(latch_data), 32'h3C);
      for (int k = 1; k <= 10; k++) begin
         req_data = 8'(k * 37 + 1);
         tick();
         check($sformatf("3c data@%0d", k), 32'(latch_data), 32'h3C);
      end

`ifndef LATCH_QUEUE_EN
      // Held req, no queue: second accept one cycle after bus release
      wait_ready();
      req = 1'b1;
      req_data = 8'h11;
      tick();
      req_data = 8'h22;
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (k == 9) req = 1'b0;
         check($sformatf("b2b bus@%0d", k),    32'(bus_drive),
               32'((k < 8) || (k >= 9 && k < 17)));
         check($sformatf("b2b done@%0d", k),   32'(done), 32'(k == 8 || k == 17));
         check($sformatf("b2b strobe@%0d", k), 32'(latch_strobe),
               32'((k >= 2 && k < 6) || (k >= 11 && k < 15)));
         check($sformatf("b2b data@%0d", k),   32'(latch_data), (k < 9) ? 32'h11 : 32'h22);
      end
`else
      // Held req with queue: second transfer chains at E0+8
      wait_ready();
      req = 1'b1;
      req_data = 8'h11;
      tick();
      check("q e0 ready", 32'(ready), 32'd1);
      req_data = 8'h22;
      tick();
      req = 1'b0;
      check("q e1 ready", 32'(ready),      32'd0);
      check("q e1 data",  32'(latch_data), 32'h11);
      for (int k = 2; k <= 17; k++) begin
         tick();
         check($sformatf("q bus@%0d", k),    32'(bus_drive), 32'(k < 16));
         check($sformatf("q done@%0d", k),   32'(done),      32'(k == 8 || k == 16));
         check($sformatf("q strobe@%0d", k), 32'(latch_strobe),
               32'((k >= 2 && k < 6) || (k >= 10 && k < 14)));
         check($sformatf("q data@%0d", k),   32'(latch_data), (k < 8) ? 32'h11 : 32'h22);
         if (k == 8) check("q ready@8", 32'(ready), 32'd1);
      end
`endif

      // Reset while strobe is high
      wait_ready();
      req = 1'b1;
      req_data = 8'h5A;
      tick();
      req = 1'b0;
      repeat (4) tick();
      check("abort strobe@4", 32'(latch_strobe), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort strobe", 32'(latch_strobe), 32'd0);
      check("abort bus",    32'(bus_drive),    32'd0);
      check("abort data",   32'(latch_data),   32'd0);
      check("abort ready",  32'(ready),        32'd0);
      check("abort done",   32'(done),         32'd0);
      repeat (2) tick();
      check("abort held ready", 32'(ready), 32'd0);
      reset_n = 1'b1;
      tick();
      check("abort release ready", 32'(ready), 32'd1);
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("abort no done@%0d", k),   32'(done),         32'd0);
         check($sformatf("abort no strobe@%0d", k), 32'(latch_strobe), 32'd0);
      end

      // Minimum timing instance, 1/1/1
      check("min ready", 32'(ready_m), 32'd1);
      req_m = 1'b1;
      req_data_m = 8'h77;
      tick();
      req_m = 1'b0;
      check("min e0 bus",    32'(bus_drive_m),    32'd1);
      check("min e0 strobe", 32'(latch_strobe_m), 32'd0);
      check("min e0 data",   32'(latch_data_m),   32'h77);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("min strobe@%0d", k), 32'(latch_strobe_m), 32'(k == 1));
         check($sformatf("min bus@%0d", k),    32'(bus_drive_m),    32'(k < 3));
         check($sformatf("min done@%0d", k),   32'(done_m),         32'(k == 3));
         check($sformatf("min data@%0d", k),   32'(latch_data_m),   32'h77);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
